pop_counter_bank: RTL and testbench

Parametrised bank of per-channel pop counters for the FIFO output stage. Each channel counts valid pops (pop asserted while its FIFO is not empty), with a selectable wrap or saturate mode, sticky overflow flags, optional clear-on-read, and a synchronous global clear. Counters are read one at a time through a req/idx interface, gated by the system IDLE state, with a registered single-cycle-valid response. It sits beside the output FIFOs and feeds the test/probe logic.

---
 rtl/pop_counter_bank.sv | 120 ++++++++++++
 tb/tb_pop_counter_bank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pop_counter_bank.sv
// Bank of per-channel pop counters with wrap/saturate modes, sticky overflow flags,
// optional clear-on-read and an IDLE-gated, registered single-index read port.
module pop_counter_bank #(
  parameter int NCH           = 4,
  parameter int CW            = 5,
  parameter int IDXW          = 2,
  parameter int SATURATE      = 0,
  parameter int CLEAR_ON_READ = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  pop,
  input  logic [NCH-1:0]  empty,
  input  logic            idle,
  input  logic            req,
  input  logic [IDXW-1:0] idx,
  input  logic            clr,
  output logic [CW-1:0]   data_out,
  output logic            valid_out,
  output logic            err_out,
  output logic [NCH-1:0]  overflow
);

  localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [IDXW:0]   NCH_L    = NCH[IDXW:0];

  logic [CW-1:0] cnt_r [NCH];
  logic          ovf_r [NCH];
  logic          accept_s;
  logic          idx_ok_s;
  logic [CW-1:0] rd_cnt_s;
  logic [CW-1:0] data_r;
  logic          valid_r;
  logic          err_r;

  // Read acceptance and an AND-OR mux of the pre-increment counts; out-of-range idx selects nothing.
  always_comb begin
    accept_s = req & idle;
    idx_ok_s = ({1'b0, idx} < NCH_L);
    rd_cnt_s = CNT_ZERO;
    for (int i = 0; i < NCH; i++) begin
      rd_cnt_s = rd_cnt_s | (cnt_r[i] & {CW{idx == IDXW'(i)}});
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic          ev_s;
    logic          cor_hit_s;
    logic [CW-1:0] base_cnt_s;
    logic          base_ovf_s;
    logic [CW-1:0] cnt_nxt_s;
    logic          ovf_nxt_s;

    // Next state: clr beats clear-on-read, which beats the count event applied on top of it.
    always_comb begin
      ev_s      = pop[g] & ~empty[g];
      cor_hit_s = (CLEAR_ON_READ != 0) && accept_s && (idx == IDXW'(g));
      if (cor_hit_s) begin
        base_cnt_s = CNT_ZERO;
        base_ovf_s = 1'b0;
      end else begin
        base_cnt_s = cnt_r[g];
        base_ovf_s = ovf_r[g];
      end
      if (clr) begin
        cnt_nxt_s = CNT_ZERO;
        ovf_nxt_s = 1'b0;
      end else if (ev_s) begin
        if (base_cnt_s == CNT_MAX) begin
          cnt_nxt_s = (SATURATE != 0) ? CNT_MAX : CNT_ZERO;
          ovf_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = base_cnt_s + CNT_ONE;
          ovf_nxt_s = base_ovf_s;
        end
      end else begin
        cnt_nxt_s = base_cnt_s;
        ovf_nxt_s = base_ovf_s;
      end
    end

    // Per-channel count and sticky overflow registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_r[g] <= CNT_ZERO;
        ovf_r[g] <= 1'b0;
      end else begin
        cnt_r[g] <= cnt_nxt_s;
        ovf_r[g] <= ovf_nxt_s;
      end
    end

    assign overflow[g] = ovf_r[g];
  end

  // Read response: one-cycle valid, data held between responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r  <= CNT_ZERO;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      valid_r <= accept_s;
      if (accept_s) begin
        data_r <= rd_cnt_s;
        err_r  <= ~idx_ok_s;
      end else begin
        data_r <= data_r;
        err_r  <= err_r;
      end
    end
  end

  assign data_out  = data_r;
  assign valid_out = valid_r;
  assign err_out   = err_r;

endmodule

// File: tb/tb_pop_counter_bank.sv
// Randomised and directed bench for pop_counter_bank: instance A (4 ch, wrap) and
// instance B (3 ch, saturate, clear-on-read) share stimulus and a behavioural model.
module tb_pop_counter_bank;

  localparam int CW   = 5;
  localparam int IDXW = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pop, empty;
  logic       idle, req, clr;
  logic [1:0] idx;

  logic [CW-1:0] data_a, data_b;
  logic          valid_a, valid_b, err_a, err_b;
  logic [3:0]    ovf_a;
  logic [2:0]    ovf_b;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  pop_counter_bank #(.NCH(4), .CW(CW), .IDXW(IDXW), .SATURATE(0), .CLEAR_ON_READ(0)) u_a (
    .clk(clk), .reset(reset), .pop(pop), .empty(empty), .idle(idle), .req(req),
    .idx(idx), .clr(clr), .data_out(data_a), .valid_out(valid_a), .err_out(err_a),
    .overflow(ovf_a)
  );

  pop_counter_bank #(.NCH(3), .CW(CW), .IDXW(IDXW), .SATURATE(1), .CLEAR_ON_READ(1)) u_b (
    .clk(clk), .reset(reset), .pop(pop[2:0]), .empty(empty[2:0]), .idle(idle), .req(req),
    .idx(idx), .clr(clr), .data_out(data_b), .valid_out(valid_b), .err_out(err_b),
    .overflow(ovf_b)
  );

  // Behavioural model: per instance k, plain integer counts and flags.
  int m_nch [2] = '{4, 3};
  bit m_sat [2] = '{1'b0, 1'b1};
  bit m_cor [2] = '{1'b0, 1'b1};
  int m_cnt [2][4];
  bit m_ovf [2][4];
  int m_data [2];
  bit m_valid [2];
  bit m_err [2];

  always @(posedge clk or negedge reset) begin : model
    int c;
    bit o;
    bit acc;
    int ix;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_data[k]  <= 0;
        m_valid[k] <= 1'b0;
        m_err[k]   <= 1'b0;
        for (int i = 0; i < 4; i++) begin
          m_cnt[k][i] <= 0;
          m_ovf[k][i] <= 1'b0;
        end
      end
    end else begin
      acc = (req === 1'b1) && (idle === 1'b1);
      ix  = int'(idx);
      for (int k = 0; k < 2; k++) begin
        m_valid[k] <= acc;
        if (acc) begin
          if (ix < m_nch[k]) begin
            m_data[k] <= m_cnt[k][ix];
            m_err[k]  <= 1'b0;
          end else begin
            m_data[k] <= 0;
            m_err[k]  <= 1'b1;
          end
        end
        for (int i = 0; i < m_nch[k]; i++) begin
          c = m_cnt[k][i];
          o = m_ovf[k][i];
          if (clr) begin
            c = 0;
            o = 1'b0;
          end else begin
            if (acc && m_cor[k] && ix == i) begin
              c = 0;
              o = 1'b0;
            end
            if (pop[i] && !empty[i]) begin
              if (c == 31) begin
                o = 1'b1;
                if (!m_sat[k]) c = 0;
              end else begin
                c = c + 1;
              end
            end
          end
          m_cnt[k][i] <= c;
          m_ovf[k][i] <= o;
        end
      end
    end
  end

  function automatic int ovf_exp(input int k);
    int v = 0;
    for (int i = 0; i < m_nch[k]; i++) v = v | (int'(m_ovf[k][i]) << i);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act === 32'(exp)) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("valid_a", 32'(valid_a), int'(m_valid[0]));
      if (m_valid[0]) check("err_a", 32'(err_a), int'(m_err[0]));
      check("data_a", 32'(data_a), m_data[0]);
      check("ovf_a", 32'(ovf_a), ovf_exp(0));
      check("valid_b", 32'(valid_b), int'(m_valid[1]));
      if (m_valid[1]) check("err_b", 32'(err_b), int'(m_err[1]));
      check("data_b", 32'(data_b), m_data[1]);
      check("ovf_b", 32'(ovf_b), ovf_exp(1));
    end
  end

  task automatic step(input logic [3:0] p, input logic [3:0] e, input logic id,
                      input logic rq, input logic [1:0] ix, input logic cl);
    pop = p; empty = e; idle = id; req = rq; idx = ix; clr = cl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    pop = 4'd0; empty = 4'd0; idle = 1'b0; req = 1'b0; idx = 2'd0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_data", 32'(data_a), 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_ovf", 32'(ovf_a), 0);
    reset = 1'b1;
    check_en = 1'b1;

    // 7 real pops on ch2, 3 ignored pops on empty ch0
    repeat (7) step(4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (3) step(4'b0001, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0);
    check("s1_rd2_data", 32'(data_a), 7);
    check("s1_rd2_valid", 32'(valid_a), 1);
    step(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
    check("s1_rd0_data", 32'(data_a), 0);
    check("s1_b2b_valid", 32'(valid_a), 1);
    step(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
    check("s1_valid_drop", 32'(valid_a), 0);

    // 33 pops on ch1: wrap gives 1, saturate gives 31
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    repeat (33) step(4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    check("s2_ovf_a", 32'(ovf_a), 2);
    check("s2_ovf_b", 32'(ovf_b), 2);
    step(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0);
    check("s2_wrap_data", 32'(data_a), 1);
    check("s2_sat_data", 32'(data_b), 31);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    check("s2_cor_ovf_b", 32'(ovf_b), 0);
    check("s2_keep_ovf_a", 32'(ovf_a), 2);

    // clear-on-read with a simultaneous pop
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    repeat (5) step(4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    step(4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
    check("s3_rd_b", 32'(data_b), 5);
    check("s3_rd_a", 32'(data_a), 5);
    step(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
    check("s3_rd2_b", 32'(data_b), 1);
    check("s3_rd2_a", 32'(data_a), 6);

    // idle gating, then an out-of-range index on the 3-channel bank
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0);
    check("s4_gate_a", 32'(valid_a), 0);
    check("s4_gate_b", 32'(valid_b), 0);
    step(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0);
    check("s4_err_valid", 32'(valid_b), 1);
    check("s4_err_b", 32'(err_b), 1);
    check("s4_err_data", 32'(data_b), 0);
    check("s4_ok_a", 32'(err_a), 0);

    // clr together with a read of ch1 holding 9
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    repeat (9) step(4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    step(4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1);
    check("s5_clr_rd_a", 32'(data_a), 9);
    check("s5_clr_rd_b", 32'(data_b), 9);
    step(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0);
    check("s5_after_a", 32'(data_a), 0);
    check("s5_after_ovf", 32'(ovf_a), 0);

    // reset asserted during a response cycle
    step(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0);
    check("s6_pre_valid", 32'(valid_a), 1);
    reset = 1'b0;
    #1;
    check("s6_rst_valid_a", 32'(valid_a), 0);
    check("s6_rst_valid_b", 32'(valid_b), 0);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    reset = 1'b1;

    // randomised traffic
    repeat (3000) begin
      step(4'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1),
           2'($urandom),
           ($urandom_range(0, 99) == 0));
    end

    step(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
